flaw_alarm_gen: RTL and testbench
=================================

// Module: flaw_alarm_gen
// PURPOSE
//  Alarm initiator for the flaw-detect datapath; drives alarm_en into the buzzer block.
//  Watches digitised echo amplitude inside the evaluation gate.
//  Fires a one-cycle alarm_en pulse after HIT_CNT consecutive valid samples exceed threshold.
//  Then ignores input for HOLDOFF cycles, so the buzzer's 1 s pulse completes before re-arm.
// PARAMETERS
//  DATA_W   12                  sample/threshold width, unsigned
//  HIT_CNT  4                   consecutive over-threshold samples needed; 0 treated as 1
//  HOLDOFF  32'd100_000_100     dead cycles after alarm; must exceed buzzer pulse (1e8+2)
// PORTS
//  clk           in   1       system clock
//  reset_n       in   1       async active-low reset
//  sample_valid  in   1       sample_data valid this cycle
//  sample_data   in   DATA_W  echo amplitude, unsigned
//  gate_open     in   1       evaluation window; level, synchronous to clk
//  threshold     in   DATA_W  alarm level; compared live, not latched
//  alarm_en      out  1       1-cycle alarm pulse to buzzer
//  alarm_count   out  16      alarms fired since reset, saturating
//  peak_amp      out  DATA_W  max sample in current/last gate (see CONFIGURATION)
// BEHAVIOUR
//  Reset: async assert.
//   - Outputs alarm_en=0, alarm_count=0, peak_amp=0.
//   - State=IDLE; hit counter=0; holdoff counter=0.
//  hit  = sample_valid & gate_open & (sample_data > threshold)   // strict, unsigned
//  miss = sample_valid & gate_open & ~(sample_data > threshold)
//  States:
//   IDLE: hit ctr=0.
//    - gate_open=1 -> ARMED, and the same-cycle sample is evaluated.
//   ARMED:
//    - hit: ctr+1.  miss: ctr=0.  No sample_valid: ctr held.
//    - gate_open=0 -> IDLE, ctr=0.
//    - Hit making ctr==HIT_CNT at edge k -> FIRE.
//   FIRE: alarm_en=1 for exactly the cycle after edge k; alarm_count+1, stops at 16'hFFFF.
//    - ctr=0 -> HOLDOFF.
//   HOLDOFF: input ignored; alarm_en=0.
//    - Counter runs 0..HOLDOFF-1, then -> IDLE, re-entering ARMED next cycle if gate still open.
//  Latency: HIT_CNT-th hit sampled at edge k -> alarm_en high k..k+1. One pulse per HOLDOFF.
//  Boundaries:
//   - HIT_CNT=1: first hit alarms.
//   - sample==threshold is a miss.
//   - Gate closing on the same edge as the HIT_CNT-th hit: hit counts, FIRE wins.
//   - Gate toggling during HOLDOFF has no effect.
//   - reset_n low mid-HOLDOFF or in FIRE: immediate return to reset values; no pulse stretch.
//  Widths: hit ctr sized $clog2(HIT_CNT+1); holdoff ctr 32 bit; no wrap of alarm_count.
// CONFIGURATION
//  PEAK_HOLD_EN defined:
//   - peak_amp <= max(peak_amp, sample_data) on each valid sample while gate_open, incl. HOLDOFF.
//   - Cleared to 0 on gate_open rising edge (first cycle of gate); held after gate closes.
//  PEAK_HOLD_EN undefined: peak_amp constant 0, no compare logic.
//  Port list identical in both builds.
// TESTING  (sim with HIT_CNT=4, HOLDOFF=10, DATA_W=12)
//  1) gate=1, thr=100, 4 valid samples 200 back-to-back
//     -> alarm_en high 1 cycle after 4th; alarm_count=1.
//  2) Samples 200,200,200,50,200,200,200 -> no alarm (miss clears ctr).
//     A 4th consecutive 200 then alarms.
//  3) sample_valid gaps of 3 cycles between 4 hits -> alarm still fires (ctr held).
//  4) Continuous hits for 40 cycles -> pulses spaced by FIRE+10 HOLDOFF+IDLE+4 hits.
//     Never back-to-back.
//  5) Sample == thr (100/100) x4 -> no alarm. Gate closed with hits -> no alarm, ctr cleared.
//  6) reset_n low 3 cycles into HOLDOFF -> all outputs 0. With PEAK_HOLD_EN, samples 30,900,400
//     -> peak_amp=900; next gate open -> 0.

Source files
------------

// File: rtl/flaw_alarm_gen.sv
// Flaw alarm initiator: one-cycle alarm_en after HIT_CNT consecutive over-threshold samples in gate, then HOLDOFF dead cycles.
// Latency: alarm_en rises on the edge that samples the HIT_CNT-th hit. No backpressure; inputs ignored during FIRE/HOLDOFF.
// Optional macro PEAK_HOLD_EN enables the per-gate peak amplitude tracker on peak_amp.
module flaw_alarm_gen #(
   parameter int          DATA_W  = 12,
   parameter int          HIT_CNT = 4,
   parameter logic [31:0] HOLDOFF = 32'd100_000_100
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              gate_open,
   input  logic [DATA_W-1:0] threshold,
   output logic              alarm_en,
   output logic [15:0]       alarm_count,
   output logic [DATA_W-1:0] peak_amp
);

   localparam int          HC      = (HIT_CNT < 1) ? 1 : HIT_CNT;
   localparam int          CW      = $clog2(HC + 1);
   localparam logic [CW-1:0] HC_V  = CW'(HC);
   localparam logic [31:0] HO_LAST = (HOLDOFF == 32'd0) ? 32'd0 : HOLDOFF - 32'd1;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FIRE, S_HOLDOFF} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_hit_ctr, w_hit_ctr_nxt;
   logic [31:0]   r_ho_ctr, w_ho_ctr_nxt;
   logic          r_alarm_en;
   logic [15:0]   r_alarm_count;
   logic          w_over, w_hit, w_miss;

   assign w_over = sample_data > threshold;
   assign w_hit  = sample_valid & gate_open & w_over;
   assign w_miss = sample_valid & gate_open & ~w_over;

   // IDLE and ARMED evaluate samples identically, so the first gated cycle already counts
   always_comb begin
      w_state_nxt   = r_state;
      w_hit_ctr_nxt = r_hit_ctr;
      w_ho_ctr_nxt  = r_ho_ctr;
      case (r_state)
         S_IDLE, S_ARMED: begin
            if (!gate_open) begin
               w_state_nxt   = S_IDLE;
               w_hit_ctr_nxt = '0;
            end else if (w_hit) begin
               if (r_hit_ctr == HC_V - 1'b1) begin
                  w_state_nxt   = S_FIRE;
                  w_hit_ctr_nxt = HC_V;
               end else begin
                  w_state_nxt   = S_ARMED;
                  w_hit_ctr_nxt = r_hit_ctr + 1'b1;
               end
            end else if (w_miss) begin
               w_state_nxt   = S_ARMED;
               w_hit_ctr_nxt = '0;
            end else begin
               w_state_nxt   = S_ARMED;
            end
         end
         S_FIRE: begin
            w_state_nxt   = S_HOLDOFF;
            w_hit_ctr_nxt = '0;
            w_ho_ctr_nxt  = '0;
         end
         S_HOLDOFF: begin
            if (r_ho_ctr == HO_LAST) begin
               w_state_nxt  = S_IDLE;
               w_ho_ctr_nxt = '0;
            end else begin
               w_ho_ctr_nxt = r_ho_ctr + 32'd1;
            end
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_hit_ctr_nxt = '0;
            w_ho_ctr_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_hit_ctr     <= '0;
         r_ho_ctr      <= '0;
         r_alarm_en    <= 1'b0;
         r_alarm_count <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_hit_ctr  <= w_hit_ctr_nxt;
         r_ho_ctr   <= w_ho_ctr_nxt;
         r_alarm_en <= (w_state_nxt == S_FIRE);
         if ((w_state_nxt == S_FIRE) && (r_alarm_count != 16'hFFFF))
            r_alarm_count <= r_alarm_count + 16'd1;
      end
   end

   assign alarm_en    = r_alarm_en;
   assign alarm_count = r_alarm_count;

`ifdef PEAK_HOLD_EN
   logic              r_gate_d;
   logic [DATA_W-1:0] r_peak;
   logic              w_gate_rise;

   assign w_gate_rise = gate_open & ~r_gate_d;

   // Tracks regardless of FSM state so the peak survives HOLDOFF
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_gate_d <= 1'b0;
         r_peak   <= '0;
      end else begin
         r_gate_d <= gate_open;
         if (w_gate_rise)
            r_peak <= sample_valid ? sample_data : '0;
         else if (gate_open && sample_valid && (sample_data > r_peak))
            r_peak <= sample_data;
      end
   end

   assign peak_amp = r_peak;
`else
   assign peak_amp = '0;
`endif

endmodule

// File: tb/tb_flaw_alarm_gen.sv
// Bench for flaw_alarm_gen with HIT_CNT=4, HOLDOFF=10, DATA_W=12.
module tb_flaw_alarm_gen;
   localparam int DW = 12;

   logic          clk          = 1'b0;
   logic          reset_n      = 1'b1;
   logic          sample_valid = 1'b0;
   logic [DW-1:0] sample_data  = '0;
   logic          gate_open    = 1'b0;
   logic [DW-1:0] threshold    = '0;
   logic          alarm_en;
   logic [15:0]   alarm_count;
   logic [DW-1:0] peak_amp;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   typedef struct packed {
      logic          v;
      logic [DW-1:0] d;
      logic          g;
      logic [DW-1:0] t;
      logic          a;
   } vec_t;

   typedef struct packed {
      logic        a;
      logic [15:0] c;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   flaw_alarm_gen #(.DATA_W(DW), .HIT_CNT(4), .HOLDOFF(32'd10)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .gate_open    (gate_open),
      .threshold    (threshold),
      .alarm_en     (alarm_en),
      .alarm_count  (alarm_count),
      .peak_amp     (peak_amp)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [DW-1:0] d, input logic g,
                       input logic [DW-1:0] t, input logic a);
      exp_t e;
      sample_valid = v;
      sample_data  = d;
      gate_open    = g;
      threshold    = t;
      if (a) exp_cnt++;
      e.a = a;
      e.c = 16'(exp_cnt);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("alarm_en", {31'd0, alarm_en}, {31'd0, e.a});
      check("alarm_count", {16'd0, alarm_count}, {16'd0, e.c});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 12'd100, 1'b0);
   endtask

   task automatic add(input logic v, input logic [DW-1:0] d, input logic g,
                      input logic [DW-1:0] t, input logic a);
      vec_t x;
      x.v = v; x.d = d; x.g = g; x.t = t; x.a = a;
      tbl.push_back(x);
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) add(1'b0, '0, 1'b0, 12'd100, 1'b0);
   endtask

   task automatic assert_reset(input string tag);
      reset_n = 1'b0;
      #1;
      sb.delete();
      exp_cnt = 0;
      check({tag, "_alarm_en"}, {31'd0, alarm_en}, 32'd0);
      check({tag, "_alarm_count"}, {16'd0, alarm_count}, 32'd0);
      check({tag, "_peak_amp"}, {20'd0, peak_amp}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      logic [DW-1:0] exp_peak;
      logic g;

      // Table: basic alarm, miss clearing, valid gaps, equality, gate-closed, width extremes
      for (int i = 0; i < 3; i++) add(1'b1, 12'd200, 1'b1, 12'd100, 1'b0);
      add(1'b1, 12'd200, 1'b1, 12'd100, 1'b1);
      add_idle(12);
      for (int i = 0; i < 3; i++) add(1'b1, 12'd200, 1'b1, 12'd100, 1'b0);
      add(1'b1, 12'd50, 1'b1, 12'd100, 1'b0);
      for (int i = 0; i < 3; i++) add(1'b1, 12'd200, 1'b1, 12'd100, 1'b0);
      add(1'b1, 12'd200, 1'b1, 12'd100, 1'b1);
      add_idle(12);
      for (int h = 0; h < 4; h++) begin
         add(1'b1, 12'd200, 1'b1, 12'd100, (h == 3));
         if (h < 3) for (int k = 0; k < 3; k++) add(1'b0, 12'd999, 1'b1, 12'd100, 1'b0);
      end
      add_idle(12);
      for (int i = 0; i < 4; i++) add(1'b1, 12'd100, 1'b1, 12'd100, 1'b0);
      add(1'b0, '0, 1'b0, 12'd100, 1'b0);
      for (int i = 0; i < 4; i++) add(1'b1, 12'd200, 1'b0, 12'd100, 1'b0);
      for (int i = 0; i < 3; i++) add(1'b1, 12'd200, 1'b1, 12'd100, 1'b0);
      add(1'b1, 12'd200, 1'b0, 12'd100, 1'b0);
      for (int i = 0; i < 3; i++) add(1'b1, 12'd200, 1'b1, 12'd100, 1'b0);
      add(1'b1, 12'd200, 1'b1, 12'd100, 1'b1);
      add_idle(12);
      add(1'b1, 12'd0, 1'b1, 12'd0, 1'b0);
      add(1'b1, 12'd4095, 1'b1, 12'd4095, 1'b0);
      for (int i = 0; i < 3; i++) add(1'b1, 12'd4095, 1'b1, 12'd4094, 1'b0);
      add(1'b1, 12'd4095, 1'b1, 12'd4094, 1'b1);
      add_idle(12);

      #2;
      assert_reset("reset");

      foreach (tbl[i]) step(tbl[i].v, tbl[i].d, tbl[i].g, tbl[i].t, tbl[i].a);

      // Continuous hits for 40 cycles, gate toggling while in FIRE/HOLDOFF
      pulses = 0;
      for (int i = 1; i <= 40; i++) begin
         g = ((i % 15) >= 1 && (i % 15) <= 4) ? 1'b1 : i[0];
         step(1'b1, 12'd200, g, 12'd100, ((i % 15) == 4));
         if (alarm_en) pulses++;
      end
      check("pulses_in_40", pulses, 32'd3);
      idle(12);

      // Reset three cycles into HOLDOFF
      for (int i = 0; i < 3; i++) step(1'b1, 12'd200, 1'b1, 12'd100, 1'b0);
      step(1'b1, 12'd200, 1'b1, 12'd100, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 12'd100, 1'b0);
      assert_reset("rst_holdoff");

      // Re-arm straight after reset, then reset while in FIRE
      for (int i = 0; i < 3; i++) step(1'b1, 12'd200, 1'b1, 12'd100, 1'b0);
      step(1'b1, 12'd200, 1'b1, 12'd100, 1'b1);
      assert_reset("rst_fire");
      idle(2);

      // Peak tracking
`ifdef PEAK_HOLD_EN
      exp_peak = 12'd900;
`else
      exp_peak = 12'd0;
`endif
      step(1'b0, '0, 1'b1, 12'd1000, 1'b0);
      step(1'b1, 12'd30, 1'b1, 12'd1000, 1'b0);
      step(1'b1, 12'd900, 1'b1, 12'd1000, 1'b0);
      step(1'b1, 12'd400, 1'b1, 12'd1000, 1'b0);
      step(1'b0, '0, 1'b0, 12'd1000, 1'b0);
      check("peak_after_gate", {20'd0, peak_amp}, {20'd0, exp_peak});
      step(1'b1, 12'd2000, 1'b0, 12'd1000, 1'b0);
      check("peak_held_closed", {20'd0, peak_amp}, {20'd0, exp_peak});
      step(1'b0, '0, 1'b1, 12'd1000, 1'b0);
      check("peak_cleared_on_open", {20'd0, peak_amp}, 32'd0);
`ifdef PEAK_HOLD_EN
      exp_peak = 12'd50;
`else
      exp_peak = 12'd0;
`endif
      step(1'b1, 12'd50, 1'b1, 12'd1000, 1'b0);
      check("peak_new_gate", {20'd0, peak_amp}, {20'd0, exp_peak});
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
